// File: rtl/spi_host_pkg.sv
// ----------------------------------------------------------------------------
// spi_host_pkg
// Shared types and constants for the SPI host transaction engine.
//   spi_state_e  : transaction FSM states
//   BYTE_W       : width of the TX/RX byte
//   BIT_CNT_W    : width of the per-byte bit counter (must hold 0..BYTE_W)
//   spi_latency(): CLK cycles from accepted start to the done pulse
// ----------------------------------------------------------------------------
package spi_host_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StTx,
        StGap,
        StRx,
        StHold
    } spi_state_e;

    // One SCLK period = 2*clk_div CLK cycles. SETUP + 8 TX + HOLD periods always,
    // GAP + 8 RX periods for reads; +1 because done is registered.
    function automatic int unsigned spi_latency(input int unsigned clk_div,
                                                input int unsigned gap_bits,
                                                input bit          do_read);
        int unsigned cyc;
        cyc = 2 * clk_div * (1 + BYTE_W + 1);
        if (do_read) begin
            cyc = cyc + 2 * clk_div * (gap_bits + BYTE_W);
        end
        return cyc + 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// ----------------------------------------------------------------------------
// spi_sclk_gen
// Divides clk_i into a mode-0 serial clock. While en_i is high a counter runs
// 0..CLK_DIV-1; at its terminal count the serial clock toggles and a one-cycle
// rise or fall tick is flagged (combinationally, in the cycle before the
// toggle takes effect). With en_i low the counter and clock clear to 0.
// Ports:
//   clk_i, rst_i  : system clock, asynchronous active-high reset
//   en_i          : run the divider
//   sclk_o        : divided clock, idle low
//   rise_tick_o   : the coming edge drives sclk_o 0->1
//   fall_tick_o   : the coming edge drives sclk_o 1->0
// ----------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;
    logic            term;

    assign term = en_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign rise_tick_o = term & ~sclk_q;
    assign fall_tick_o = term & sclk_q;

endmodule

// File: rtl/spi_host_ctrl.sv
// ----------------------------------------------------------------------------
// spi_host_ctrl
// SPI mode-0 master. Each transaction asserts CS, shifts one byte out MSB
// first, optionally idles GAP_BITS SCLK periods and shifts one byte in from
// MISO, then releases CS and pulses done.
// Optional build macro: SPI_HOST_ABORT_EN adds abort_i / aborted_o.
// Ports:
//   clk_i, rst_i       : system clock, asynchronous active-high reset
//   start_i            : request, accepted only when idle and not on done
//   tx_data_i          : byte to send, captured on accepted start
//   do_read_i          : 1 = gap + read phase, 0 = write-only
//   abort_i, aborted_o : (SPI_HOST_ABORT_EN) cancel request / one-cycle ack
//   busy_o             : transaction in flight
//   done_o             : one-cycle completion pulse
//   rx_data_o          : last fully received byte
//   sclk_o, mosi_o     : serial clock (idle low) and data out
//   miso_i             : serial data in, sampled raw
//   cs_o               : chip select, active level CS_ACTIVE
// ----------------------------------------------------------------------------
module spi_host_ctrl
    import spi_host_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 5,
    parameter int unsigned GAP_BITS  = 5,
    parameter bit          CS_ACTIVE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              do_read_i,
`ifdef SPI_HOST_ABORT_EN
    input  logic              abort_i,
    output logic              aborted_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_o
);

    localparam logic                 CsOn    = CS_ACTIVE;
    localparam logic [BIT_CNT_W-1:0] BitLast = BIT_CNT_W'(BYTE_W - 1);
    localparam logic [BIT_CNT_W-1:0] BitDone = BIT_CNT_W'(BYTE_W);
    localparam int unsigned          GapW    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GapW-1:0]      GapLast = GapW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    spi_state_e           state_q, state_d;
    logic [BYTE_W-2:0]    tx_sr_q, tx_sr_d;   // bits still to send after the current MOSI bit
    logic [BYTE_W-2:0]    rx_sr_q, rx_sr_d;   // first seven received bits
    logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
    logic                 rd_q, rd_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_q, cs_d;
    logic                 done_q, done_d;

    logic gen_en, gen_sclk, rise_tick, fall_tick;
    logic abort_req, abort_hit;

`ifdef SPI_HOST_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    assign gen_en    = (state_q != StIdle);
    assign abort_hit = abort_req && (state_q != StIdle);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (gen_en),
        .sclk_o      (gen_sclk),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rd_d      = rd_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done_q blocks a start landing in the completion cycle
                if (start_i && !done_q) begin
                    state_d   = StSetup;
                    tx_sr_d   = tx_data_i[BYTE_W-2:0];
                    rd_d      = do_read_i;
                    cs_d      = CsOn;
                    mosi_d    = tx_data_i[BYTE_W-1];
                    bit_cnt_d = BitLast;
                end
            end
            // Divider runs through one period but SCLK stays masked low.
            StSetup: begin
                if (fall_tick) begin
                    state_d = StTx;
                end
            end
            StTx: begin
                if (fall_tick) begin
                    if (bit_cnt_q == '0) begin
                        mosi_d    = 1'b0;
                        gap_cnt_d = '0;
                        if (!rd_q) begin
                            state_d = StHold;
                        end else if (GAP_BITS == 0) begin
                            state_d = StRx;
                        end else begin
                            state_d = StGap;
                        end
                    end else begin
                        mosi_d    = tx_sr_q[BYTE_W-2];
                        tx_sr_d   = {tx_sr_q[BYTE_W-3:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
            end
            StGap: begin
                if (fall_tick) begin
                    if (gap_cnt_q == GapLast) begin
                        state_d = StRx;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            StRx: begin
                if (rise_tick) begin
                    rx_sr_d   = {rx_sr_q[BYTE_W-3:0], miso_i};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Publish only the complete byte.
                    if (bit_cnt_q == BitLast) begin
                        rx_data_d = {rx_sr_q, miso_i};
                    end
                end else if (fall_tick && (bit_cnt_q == BitDone)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (fall_tick) begin
                    state_d = StIdle;
                    cs_d    = ~CsOn;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cs_d    = ~CsOn;
            end
        endcase

        if (abort_hit) begin
            state_d   = StIdle;
            cs_d      = ~CsOn;
            mosi_d    = 1'b0;
            done_d    = 1'b0;
            rx_data_d = rx_data_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rd_q      <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= ~CsOn;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rd_q      <= rd_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
        end
    end

`ifdef SPI_HOST_ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
        end
    end

    assign aborted_o = aborted_q;
`endif

    // The divider free-runs in SETUP/GAP/HOLD; only TX and RX show SCLK. State
    // only changes on fall ticks, when the divider clock is already low.
    assign sclk_o    = gen_sclk & ((state_q == StTx) || (state_q == StRx));
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign mosi_o    = mosi_q;
    assign cs_o      = cs_q;

endmodule
